// File: rtl/pixel_capture.sv
// Captures a processor's pixel stream (index/pixel pairs) into a frame buffer for VGA readout.
// Write on each in-order index step; read data 1 cycle after rd_en; no backpressure, out-of-order steps resync.
module pixel_capture #(
    parameter int PIX_W  = 12,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] index,
    input  logic [PIX_W-1:0]  pixel_in,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic              frame_done,
    output logic [7:0]        frame_count,
    output logic              seq_err,
    output logic              capturing
);

    typedef enum logic {SYNC, CAPTURE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] index_q;
    logic [PIX_W-1:0]  pixel_q;
    logic [ADDR_W-1:0] index_inc;
    logic              idx_evt;
    logic              wr_en;
    logic              frame_wrap;
    logic              bad_step;

    logic [PIX_W-1:0]  mem [2**ADDR_W];

    assign idx_evt   = (index != index_q);
    assign index_inc = index_q + ADDR_W'(1);

    always_comb begin
        state_nxt  = state;
        wr_en      = 1'b0;
        frame_wrap = 1'b0;
        bad_step   = 1'b0;
        case (state)
            SYNC: begin
                if (index == '0 && !idx_evt)
                    state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (idx_evt) begin
                    if (index == index_inc) begin
                        // pixel_q is the last value held while index_q was current
                        wr_en      = 1'b1;
                        frame_wrap = (index_q == '1);
                    end else begin
                        bad_step  = 1'b1;
                        state_nxt = SYNC;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= SYNC;
            index_q     <= '0;
            pixel_q     <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 8'd0;
            seq_err     <= 1'b0;
            capturing   <= 1'b0;
        end else begin
            state      <= state_nxt;
            index_q    <= index;
            pixel_q    <= pixel_in;
            frame_done <= frame_wrap;
            if (frame_wrap)
                frame_count <= frame_count + 8'd1;
            if (bad_step)
                seq_err <= 1'b1;
            capturing <= (state == CAPTURE);
            rd_valid  <= rd_en;
            if (rd_en)
                rd_data <= mem[rd_addr];
        end
    end

    // Buffer contents survive reset; a write colliding with a read returns the old word.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en)
            mem[index_q] <= pixel_q;
    end

endmodule

// File: tb/tb_pixel_capture.sv
// Directed bench for pixel_capture: a full-size instance plus a 16-deep instance for frame-counter wrap.
module tb_pixel_capture;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // full-size instance
    logic        rst_n;
    logic [11:0] index;
    logic [11:0] pixel_in;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic [11:0] rd_data;
    logic        rd_valid;
    logic        frame_done;
    logic [7:0]  frame_count;
    logic        seq_err;
    logic        capturing;

    // small instance
    logic        rst_n2;
    logic [3:0]  index2;
    logic [11:0] pixel2;
    logic        rd_en2;
    logic [3:0]  rd_addr2;
    logic [11:0] rd_data2;
    logic        rd_valid2;
    logic        frame_done2;
    logic [7:0]  frame_count2;
    logic        seq_err2;
    logic        capturing2;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fd_cnt    = 0;
    int fd_cnt2   = 0;

    pixel_capture #(.PIX_W(12), .ADDR_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .index(index), .pixel_in(pixel_in),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .frame_done(frame_done), .frame_count(frame_count), .seq_err(seq_err),
        .capturing(capturing)
    );

    pixel_capture #(.PIX_W(12), .ADDR_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n2), .index(index2), .pixel_in(pixel2),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_valid(rd_valid2),
        .frame_done(frame_done2), .frame_count(frame_count2), .seq_err(seq_err2),
        .capturing(capturing2)
    );

    always @(negedge clk) begin
        if (frame_done === 1'b1)  fd_cnt++;
        if (frame_done2 === 1'b1) fd_cnt2++;
    end

    // all tasks enter and leave on a negedge
    task automatic drive(input logic [11:0] idx, input logic [11:0] pix, input int n);
        index    = idx;
        pixel_in = pix;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive2(input logic [3:0] idx, input logic [11:0] pix);
        index2 = idx;
        pixel2 = pix;
        @(negedge clk);
    endtask

    task automatic do_read(input logic [11:0] a, output logic [11:0] d,
                           output logic v_next, output logic v_after);
        rd_en   = 1'b1;
        rd_addr = a;
        @(negedge clk);
        d      = rd_data;
        v_next = rd_valid;
        rd_en  = 1'b0;
        @(negedge clk);
        v_after = rd_valid;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; index = '0; pixel_in = '0; rd_en = 1'b0; rd_addr = '0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({rd_data, rd_valid, frame_done, frame_count, seq_err, capturing} !== 24'd0) begin
            $display("FAIL reset_outputs: got data=%h v=%b fd=%b fc=%0d se=%b cap=%b required all zero",
                     rd_data, rd_valid, frame_done, frame_count, seq_err, capturing);
        end else pass_cnt++;
    endtask

    task automatic test_sync_entry;
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (capturing !== 1'b0) $display("FAIL sync_cap_cycle1: got %b required 0", capturing);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (capturing !== 1'b1) $display("FAIL sync_cap_cycle2: got %b required 1", capturing);
        else pass_cnt++;
        total_cnt++;
        if (frame_count !== 8'd0 || seq_err !== 1'b0)
            $display("FAIL sync_counters: got fc=%0d se=%b required 0 0", frame_count, seq_err);
        else pass_cnt++;
    endtask

    task automatic test_frame;
        int          fd0;
        logic [11:0] d;
        logic        v1, v0;
        fd0 = fd_cnt;
        for (int i = 0; i < 4096; i++) begin
            logic [11:0] iv;
            iv = i[11:0];
            drive(iv, iv ^ 12'hA5A, 3);
        end
        index    = 12'd0;
        pixel_in = 12'hA5A;
        @(negedge clk);
        total_cnt++;
        if (frame_done !== 1'b1 || frame_count !== 8'd1)
            $display("FAIL frame_wrap: got fd=%b fc=%0d required 1 1", frame_done, frame_count);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (frame_done !== 1'b0) $display("FAIL frame_done_width: got %b required 0", frame_done);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (fd_cnt - fd0 !== 1) $display("FAIL frame_pulses: got %0d required 1", fd_cnt - fd0);
        else pass_cnt++;

        do_read(12'd0, d, v1, v0);
        total_cnt++;
        if (d !== 12'hA5A || v1 !== 1'b1 || v0 !== 1'b0)
            $display("FAIL read_addr0: got d=%h v=%b,%b required A5A 1,0", d, v1, v0);
        else pass_cnt++;
        do_read(12'd1, d, v1, v0);
        total_cnt++;
        if (d !== 12'hA5B || v1 !== 1'b1 || v0 !== 1'b0)
            $display("FAIL read_addr1: got d=%h v=%b,%b required A5B 1,0", d, v1, v0);
        else pass_cnt++;
        do_read(12'd4095, d, v1, v0);
        total_cnt++;
        if (d !== 12'h5A5 || v1 !== 1'b1 || v0 !== 1'b0)
            $display("FAIL read_addr4095: got d=%h v=%b,%b required 5A5 1,0", d, v1, v0);
        else pass_cnt++;
        total_cnt++;
        if (rd_data !== 12'h5A5) $display("FAIL rd_data_hold: got %h required 5A5", rd_data);
        else pass_cnt++;
    endtask

    task automatic test_seq_err;
        logic [11:0] d;
        logic        v1, v0;
        for (int i = 1; i < 5; i++) drive(i[11:0], 12'h000, 1);
        drive(12'd5, 12'h0EE, 1);
        drive(12'd7, 12'h000, 1);
        total_cnt++;
        if (seq_err !== 1'b1) $display("FAIL skip_seq_err: got %b required 1", seq_err);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (capturing !== 1'b0) $display("FAIL skip_capturing: got %b required 0", capturing);
        else pass_cnt++;
        do_read(12'd5, d, v1, v0);
        total_cnt++;
        if (d !== 12'hA5F) $display("FAIL skip_no_write: got %h required A5F", d);
        else pass_cnt++;
        drive(12'd0, 12'h000, 4);
        total_cnt++;
        if (capturing !== 1'b1 || seq_err !== 1'b1)
            $display("FAIL resync: got cap=%b se=%b required 1 1", capturing, seq_err);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [11:0] d;
        logic        v1, v0;
        for (int i = 1; i <= 10; i++) drive(i[11:0], (i == 10) ? 12'h123 : 12'h000, 1);
        drive(12'd11, 12'h000, 1);
        drive(12'd0, 12'h000, 4);
        for (int i = 1; i <= 10; i++) drive(i[11:0], (i == 10) ? 12'h456 : 12'h000, 1);
        index   = 12'd11;
        rd_en   = 1'b1;
        rd_addr = 12'd10;
        @(negedge clk);
        rd_en = 1'b0;
        total_cnt++;
        if (rd_data !== 12'h123 || rd_valid !== 1'b1)
            $display("FAIL collide_old_data: got d=%h v=%b required 123 1", rd_data, rd_valid);
        else pass_cnt++;
        @(negedge clk);
        do_read(12'd10, d, v1, v0);
        total_cnt++;
        if (d !== 12'h456) $display("FAIL collide_new_data: got %h required 456", d);
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe;
        logic [11:0] d;
        logic        v1, v0;
        for (int i = 12; i <= 2000; i++) begin
            logic [11:0] iv;
            iv = i[11:0];
            drive(iv, ~iv, 1);
        end
        rst_n    = 1'b0;
        index    = 12'd2001;
        pixel_in = 12'hFFF;
        @(negedge clk);
        total_cnt++;
        if ({rd_data, rd_valid, frame_done, frame_count, seq_err, capturing} !== 24'd0) begin
            $display("FAIL midframe_reset: got data=%h v=%b fd=%b fc=%0d se=%b cap=%b required all zero",
                     rd_data, rd_valid, frame_done, frame_count, seq_err, capturing);
        end else pass_cnt++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (capturing !== 1'b0) $display("FAIL no_resume: got %b required 0", capturing);
        else pass_cnt++;
        do_read(12'd100, d, v1, v0);
        total_cnt++;
        if (d !== 12'hF9B || v1 !== 1'b1) $display("FAIL keep_addr100: got %h v=%b required F9B 1", d, v1);
        else pass_cnt++;
        do_read(12'd2000, d, v1, v0);
        total_cnt++;
        if (d !== 12'hD8A) $display("FAIL no_write_in_reset: got %h required D8A", d);
        else pass_cnt++;
    endtask

    task automatic test_frame_count_wrap;
        int fd0;
        rst_n2 = 1'b1;
        drive2(4'd0, 12'h000);
        drive2(4'd0, 12'h000);
        fd0 = fd_cnt2;
        for (int f = 0; f < 256; f++) begin
            for (int i = 1; i < 16; i++) drive2(i[3:0], 12'h000);
            drive2(4'd0, 12'h000);
            if (f == 0) begin
                total_cnt++;
                if (frame_count2 !== 8'd1) $display("FAIL wrap_first_frame: got %0d required 1", frame_count2);
                else pass_cnt++;
            end
        end
        drive2(4'd0, 12'h000);
        drive2(4'd0, 12'h000);
        total_cnt++;
        if (frame_count2 !== 8'd0) $display("FAIL wrap_count: got %0d required 0", frame_count2);
        else pass_cnt++;
        total_cnt++;
        if (fd_cnt2 - fd0 !== 256) $display("FAIL wrap_pulses: got %0d required 256", fd_cnt2 - fd0);
        else pass_cnt++;
        total_cnt++;
        if (seq_err2 !== 1'b0 || capturing2 !== 1'b1)
            $display("FAIL wrap_state: got se=%b cap=%b required 0 1", seq_err2, capturing2);
        else pass_cnt++;
    endtask

    initial begin
        rst_n2 = 1'b0; index2 = '0; pixel2 = '0; rd_en2 = 1'b0; rd_addr2 = '0;
        rst_n = 1'b0; index = '0; pixel_in = '0; rd_en = 1'b0; rd_addr = '0;
        @(negedge clk);
        test_reset;
        test_sync_entry;
        test_frame;
        test_seq_err;
        test_back_to_back;
        test_reset_midframe;
        test_frame_count_wrap;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pixel_capture.md
PIXEL_CAPTURE -- requirements
Module: pixel_capture

Interface
REQ-001 SHALL have parameter PIX_W, default 12, meaning width of one RGB444 pixel.
REQ-002 SHALL have parameter ADDR_W, default 12, meaning pixel-index width; buffer depth = 2**ADDR_W (4096).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port index  input  ADDR_W  processor pixel counter ($t3 low bits).
REQ-006 SHALL have port pixel_in  input  PIX_W  processor output pixel ($t6 low bits).
REQ-007 SHALL have port rd_en  input  1  VGA-side read request.
REQ-008 SHALL have port rd_addr  input  ADDR_W  VGA-side read address.
REQ-009 SHALL have port rd_data  output  PIX_W  read data.
REQ-010 SHALL have port rd_valid  output  1  rd_data valid strobe.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse on completed frame.
REQ-012 SHALL have port frame_count  output  8  completed frames, wraps 255->0.
REQ-013 SHALL have port seq_err  output  1  sticky out-of-order index flag.
REQ-014 SHALL have port capturing  output  1  high while FSM in CAPTURE.

Function
REQ-015 SHALL register index and pixel_in every cycle into index_q and pixel_q; pixel for index N is the value held while index==N.
REQ-016 SHALL detect an index event when index != index_q.
REQ-017 SHALL implement FSM states SYNC and CAPTURE; reset state SYNC.
REQ-018 SYNC: SHALL write nothing; SHALL move to CAPTURE on the first cycle with index==0 and no index event.
REQ-019 CAPTURE, index event with index == index_q+1 (mod 2**ADDR_W): SHALL write pixel_q to buffer[index_q] in that cycle.
REQ-020 CAPTURE, event with index_q == 2**ADDR_W-1 and index == 0: SHALL perform the REQ-019 write, pulse frame_done the next cycle, increment frame_count, stay in CAPTURE.
REQ-021 CAPTURE, any other index event (skip, backward step): SHALL not write, SHALL set seq_err, SHALL return to SYNC.
REQ-022 SHALL ignore index changes that are not events (index steady) -- no write, no state change.
REQ-023 Buffer: 2**ADDR_W x PIX_W, single write port, single synchronous read port, contents not reset.
REQ-024 Read: SHALL present buffer[rd_addr] on rd_data and assert rd_valid exactly 1 cycle after rd_en sampled high; rd_valid low otherwise; rd_data holds its last value when rd_en low.
REQ-025 Same-cycle read and write to one address: rd_data SHALL return the old (pre-write) contents.
REQ-026 seq_err SHALL clear only on reset.
REQ-027 capturing SHALL equal (state == CAPTURE), registered.

Reset
REQ-028 On posedge clk with rst_n low: state=SYNC, index_q=0, pixel_q=0, rd_data=0, rd_valid=0, frame_done=0, frame_count=0, seq_err=0, capturing=0.
REQ-029 Reset mid-frame SHALL abort capture without writing; buffer keeps prior contents; capture resumes only after REQ-018.
REQ-030 rst_n SHALL dominate all other inputs in the same cycle.

Verification
REQ-031 Reset, index=0 held 2 cycles -> capturing=1 on 2nd cycle after entry; frame_count=0, seq_err=0.
REQ-032 Drive index 0..4095 then 0, pixel_in=index^12'hA5A each step, 3 cycles per index -> frame_done one pulse, frame_count=1; reading addr 0,1,4095 returns 12'hA5A,12'hA5B,12'h5A5 with rd_valid 1 cycle after rd_en.
REQ-033 In CAPTURE step index 5->7 -> no write to 5, seq_err=1, capturing=0; later index=0 steady -> capturing=1, seq_err stays 1.
REQ-034 Write buffer[10]=12'h123, then same-cycle read addr 10 and write 12'h456 -> rd_data=12'h123; next read -> 12'h456.
REQ-035 Assert rst_n low at index 2000 -> all outputs reset values per REQ-028; previously captured addr 100 still readable unchanged.
REQ-036 Run 256 complete frames -> frame_count wraps to 0, 256 frame_done pulses counted.
